// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB miss controller: FSM encoding, PTE layout,
// default geometry and the page-table address helper.
package tlb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WALK  = 2'd1,
      ST_FILL  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   localparam int PTE_V = 15;
   localparam int PTE_W = 14;

   localparam int DEF_ENTRIES = 4;
   localparam int DEF_VPN_W   = 4;
   localparam int DEF_PPN_W   = 8;

   // PTEs are 16-bit words, so the table is indexed in steps of two bytes.
   function automatic logic [15:0] pte_addr(input logic [15:0] base, input logic [15:0] vpn);
      return base + {vpn[14:0], 1'b0};
   endfunction

endpackage

// File: rtl/tlb_array.sv
// Fully-associative TLB storage: parallel VPN match, single fill write port
// and a one-cycle flush of every valid bit.
module tlb_array
   import tlb_pkg::*;
#(
   parameter int ENTRIES = DEF_ENTRIES,
   parameter int VPN_W   = DEF_VPN_W,
   parameter int PPN_W   = DEF_PPN_W,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic [VPN_W-1:0] lookup_vpn,
   output logic             match,
   output logic [PPN_W-1:0] match_ppn,
   output logic             match_writable,
   input  logic             fill_en,
   input  logic [IDX_W-1:0] fill_idx,
   input  logic [VPN_W-1:0] fill_vpn,
   input  logic [PPN_W-1:0] fill_ppn,
   input  logic             fill_writable
);

   logic [ENTRIES-1:0] valid_q;
   logic [VPN_W-1:0]   vpn_q [ENTRIES];
   logic [PPN_W-1:0]   ppn_q [ENTRIES];
   logic               wr_q  [ENTRIES];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
      end else if (fill_en) begin
         valid_q[fill_idx] <= 1'b1;
      end
   end

   // NOTE: entry payloads carry no reset; a clear valid bit already hides them.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         vpn_q[fill_idx] <= fill_vpn;
         ppn_q[fill_idx] <= fill_ppn;
         wr_q[fill_idx]  <= fill_writable;
      end
   end

   // Fills only happen on a miss, so at most one entry can match and OR-ing is safe.
   always_comb begin
      // NOTE: defaults first so every path assigns each output and no latch is inferred.
      match          = 1'b0;
      match_ppn      = '0;
      match_writable = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && (vpn_q[i] == lookup_vpn)) begin
            match          = 1'b1;
            match_ppn      = match_ppn | ppn_q[i];
            match_writable = match_writable | wr_q[i];
         end
      end
   end

endmodule

// File: rtl/tlb_miss_controller.sv
// TLB lookup, miss walk and fill controller for the TLB-lookup pipeline stage.
// Optional TLB_STATS_EN adds saturating miss_count / fault_count outputs.
module tlb_miss_controller
   import tlb_pkg::*;
#(
   parameter int ENTRIES = DEF_ENTRIES,
   parameter int VPN_W   = DEF_VPN_W,
   parameter int PPN_W   = DEF_PPN_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   input  logic                    req_store,
   input  logic [15:0]             req_vaddr,
   input  logic [15:0]             ptbr,
   input  logic                    flush,
   output logic                    ptw_req,
   output logic [15:0]             ptw_addr,
   input  logic                    ptw_ack,
   input  logic [15:0]             ptw_data,
   output logic                    enable_tlblookup,
   output logic                    hit,
   output logic [16-VPN_W+PPN_W-1:0] paddr,
   output logic                    fault
`ifdef TLB_STATS_EN
   ,
   output logic [15:0]             miss_count,
   output logic [7:0]              fault_count
`endif
);

   localparam int OFF_W = 16 - VPN_W;
   localparam int IDX_W = $clog2(ENTRIES);

   state_t           state_q;
   logic [IDX_W-1:0] ptr_q;
   logic [VPN_W-1:0] walk_vpn_q;
   logic             walk_store_q;
   logic             discard_q;
   logic             dropped_q;
   logic [PPN_W-1:0] fill_ppn_q;
   logic             fill_wr_q;

   logic [VPN_W-1:0] lookup_vpn;
   logic             match;
   logic [PPN_W-1:0] match_ppn;
   logic             match_writable;
   logic             in_idle;
   logic             prot_fault;
   logic             miss;
   logic             fault_pulse;
   logic             walk_discard;
   logic             walk_dropped;
   logic             pte_fault;
   logic             fill_en;

   assign lookup_vpn = req_vaddr[15:OFF_W];
   assign in_idle    = (state_q == ST_IDLE);

   tlb_array #(
      .ENTRIES (ENTRIES),
      .VPN_W   (VPN_W),
      .PPN_W   (PPN_W),
      .IDX_W   (IDX_W)
   ) u_array (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .lookup_vpn     (lookup_vpn),
      .match          (match),
      .match_ppn      (match_ppn),
      .match_writable (match_writable),
      .fill_en        (fill_en),
      .fill_idx       (ptr_q),
      .fill_vpn       (walk_vpn_q),
      .fill_ppn       (fill_ppn_q),
      .fill_writable  (fill_wr_q)
   );

   assign prot_fault   = in_idle & req_valid & match & req_store & ~match_writable;
   assign hit          = in_idle & req_valid & match & ~prot_fault;
   assign paddr        = hit ? {match_ppn, req_vaddr[OFF_W-1:0]} : '0;
   assign miss         = in_idle & req_valid & ~match;
   // A walk whose requester left mid-walk still runs, but its fault is not reported.
   assign fault_pulse  = prot_fault | ((state_q == ST_FAULT) & ~dropped_q);
   assign fault        = fault_pulse;
   assign ptw_req      = (state_q == ST_WALK);
   assign walk_discard = discard_q | flush;
   assign walk_dropped = dropped_q | ~req_valid;
   assign pte_fault    = ~ptw_data[PTE_V] | (walk_store_q & ~ptw_data[PTE_W]);
   assign fill_en      = (state_q == ST_FILL) & ~flush;

   // Held high during reset so a controller being reset never stalls the stage.
   always_comb begin
      enable_tlblookup = 1'b1;
      case (state_q)
         ST_IDLE:          enable_tlblookup = ~(req_valid & ~hit & ~fault);
         ST_WALK, ST_FILL: enable_tlblookup = 1'b0;
         default:          enable_tlblookup = 1'b1;
      endcase
      if (!reset) enable_tlblookup = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         walk_vpn_q   <= '0;
         walk_store_q <= 1'b0;
         discard_q    <= 1'b0;
         dropped_q    <= 1'b0;
         fill_ppn_q   <= '0;
         fill_wr_q    <= 1'b0;
         ptw_addr     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (miss) begin
                  state_q      <= ST_WALK;
                  walk_vpn_q   <= lookup_vpn;
                  walk_store_q <= req_store;
                  ptw_addr     <= pte_addr(ptbr, 16'(lookup_vpn));
                  discard_q    <= 1'b0;
                  dropped_q    <= 1'b0;
               end
            end
            ST_WALK: begin
               discard_q <= walk_discard;
               dropped_q <= walk_dropped;
               if (ptw_ack) begin
                  if (walk_discard) begin
                     state_q <= ST_IDLE;
                  end else if (pte_fault) begin
                     state_q <= ST_FAULT;
                  end else begin
                     state_q    <= ST_FILL;
                     fill_ppn_q <= ptw_data[PPN_W-1:0];
                     fill_wr_q  <= ptw_data[PTE_W];
                  end
               end
            end
            ST_FILL: begin
               state_q <= ST_IDLE;
               if (!flush) ptr_q <= ptr_q + IDX_W'(1);
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   generate
      if (PPN_W < PTE_W) begin : g_pte_spare
         logic unused_pte_bits;
         assign unused_pte_bits = ^ptw_data[PTE_W-1:PPN_W];
      end
   endgenerate

`ifdef TLB_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         miss_count  <= '0;
         fault_count <= '0;
      end else begin
         if (miss && (miss_count != '1))          miss_count  <= miss_count + 16'd1;
         if (fault_pulse && (fault_count != '1))  fault_count <= fault_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tlb_miss_controller.sv
// Self-checking bench for tlb_miss_controller: transaction-level TLB model,
// per-cycle comparison, directed scenarios with literal expectations, random traffic.
module tb_tlb_miss_controller;

   localparam int ENT   = 4;
   localparam int VPN_W = 4;
   localparam int PPN_W = 8;
   localparam int PA_W  = 16 - VPN_W + PPN_W;

   logic            clk;
   logic            reset;
   logic            req_valid;
   logic            req_store;
   logic [15:0]     req_vaddr;
   logic [15:0]     ptbr;
   logic            flush;
   logic            ptw_req;
   logic [15:0]     ptw_addr;
   logic            ptw_ack;
   logic [15:0]     ptw_data;
   logic            enable_tlblookup;
   logic            hit;
   logic [PA_W-1:0] paddr;
   logic            fault;
`ifdef TLB_STATS_EN
   logic [15:0]     miss_count;
   logic [7:0]      fault_count;
`endif

   tlb_miss_controller #(
      .ENTRIES (ENT),
      .VPN_W   (VPN_W),
      .PPN_W   (PPN_W)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_store        (req_store),
      .req_vaddr        (req_vaddr),
      .ptbr             (ptbr),
      .flush            (flush),
      .ptw_req          (ptw_req),
      .ptw_addr         (ptw_addr),
      .ptw_ack          (ptw_ack),
      .ptw_data         (ptw_data),
      .enable_tlblookup (enable_tlblookup),
      .hit              (hit),
      .paddr            (paddr),
      .fault            (fault)
`ifdef TLB_STATS_EN
      ,
      .miss_count       (miss_count),
      .fault_count      (fault_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef enum {PH_IDLE, PH_WALK, PH_FILL, PH_FAULT} phase_e;

   phase_e m_phase;
   bit     m_valid [ENT];
   int     m_vpn   [ENT];
   int     m_ppn   [ENT];
   bit     m_wr    [ENT];
   int     m_ptr;
   int     w_vpn;
   bit     w_store;
   int     w_addr;
   bit     w_flushed;
   bit     w_dropped;
   int     f_ppn;
   bit     f_wr;
   bit     e_fault;
   int     m_miss;
   int     m_faults;

   int checks;
   int failures;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic int find(input int vpn);
      for (int i = 0; i < ENT; i++)
         if (m_valid[i] && m_vpn[i] == vpn) return i;
      return -1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
   endtask

   task automatic model_reset();
      model_clear();
      m_phase  = PH_IDLE;
      m_ptr    = 0;
      m_miss   = 0;
      m_faults = 0;
      e_fault  = 1'b0;
   endtask

   // Compares every DUT output against the model at the falling edge.
   task automatic sample();
      int idx;
      bit e_hit, e_en, e_req;
      int e_pa;
      @(negedge clk);
      idx = find(int'(req_vaddr[15:12]));
      e_hit = 1'b0; e_fault = 1'b0; e_pa = 0; e_en = 1'b1; e_req = 1'b0;
      case (m_phase)
         PH_IDLE: begin
            if (req_valid && idx >= 0) begin
               if (req_store && !m_wr[idx]) e_fault = 1'b1;
               else begin
                  e_hit = 1'b1;
                  e_pa  = (m_ppn[idx] << 12) | int'(req_vaddr[11:0]);
               end
            end
            e_en = !(req_valid && !e_hit && !e_fault);
         end
         PH_WALK:  begin e_req = 1'b1; e_en = 1'b0; end
         PH_FILL:  e_en = 1'b0;
         PH_FAULT: e_fault = !w_dropped;
      endcase
      check("hit", 32'(hit), 32'(e_hit));
      check("fault", 32'(fault), 32'(e_fault));
      check("paddr", 32'(paddr), e_pa);
      check("enable", 32'(enable_tlblookup), 32'(e_en));
      check("ptw_req", 32'(ptw_req), 32'(e_req));
      if (e_req) check("ptw_addr", 32'(ptw_addr), w_addr);
`ifdef TLB_STATS_EN
      check("miss_count", 32'(miss_count), m_miss);
      check("fault_count", 32'(fault_count), m_faults);
`endif
   endtask

   task automatic model_update();
      int vpn, idx;
      vpn = int'(req_vaddr[15:12]);
      idx = find(vpn);
      case (m_phase)
         PH_IDLE: begin
            if (req_valid && idx < 0) begin
               m_phase   = PH_WALK;
               w_vpn     = vpn;
               w_store   = req_store;
               w_addr    = (int'(ptbr) + 2 * vpn) & 32'hFFFF;
               w_flushed = 1'b0;
               w_dropped = 1'b0;
               if (m_miss < 16'hFFFF) m_miss++;
            end
            if (flush) model_clear();
         end
         PH_WALK: begin
            if (flush) begin w_flushed = 1'b1; model_clear(); end
            if (!req_valid) w_dropped = 1'b1;
            if (ptw_ack) begin
               if (w_flushed) m_phase = PH_IDLE;
               else if (!ptw_data[15] || (w_store && !ptw_data[14])) m_phase = PH_FAULT;
               else begin
                  m_phase = PH_FILL;
                  f_ppn   = int'(ptw_data[7:0]);
                  f_wr    = ptw_data[14];
               end
            end
         end
         PH_FILL: begin
            if (flush) model_clear();
            else begin
               m_valid[m_ptr] = 1'b1;
               m_vpn[m_ptr]   = w_vpn;
               m_ppn[m_ptr]   = f_ppn;
               m_wr[m_ptr]    = f_wr;
               m_ptr          = (m_ptr + 1) % ENT;
            end
            m_phase = PH_IDLE;
         end
         PH_FAULT: begin
            if (flush) model_clear();
            m_phase = PH_IDLE;
         end
      endcase
      if (e_fault && m_faults < 255) m_faults++;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic advance();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   task automatic set_req(input bit v, input bit st, input logic [15:0] a);
      req_valid = v;
      req_store = st;
      req_vaddr = a;
   endtask

   task automatic finish_walk(input int waits, input logic [15:0] pte);
      for (int i = 0; i < waits; i++) cycle();
      ptw_ack  = 1'b1;
      ptw_data = pte;
      cycle();
      ptw_ack  = 1'b0;
   endtask

   task automatic fill(input logic [15:0] a, input logic [15:0] pte);
      set_req(1'b1, 1'b0, a);
      cycle();
      finish_walk(1, pte);
      cycle();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("rst_ptw_req", 32'(ptw_req), 32'h0);
      check("rst_enable", 32'(enable_tlblookup), 32'h1);
      check("rst_hit", 32'(hit), 32'h0);
      check("rst_fault", 32'(fault), 32'h0);
      check("rst_paddr", 32'(paddr), 32'h0);
      check("rst_ptw_addr", 32'(ptw_addr), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      req_valid = 1'b0; req_store = 1'b0; req_vaddr = '0;
      ptbr = '0; flush = 1'b0; ptw_ack = 1'b0; ptw_data = '0;
      do_reset();

      // Cold miss: 3 wait cycles, then fill and hit on the retried lookup.
      ptbr = 16'h1000;
      set_req(1'b1, 1'b0, 16'h3ABC);
      sample(); check("cold_stall", 32'(enable_tlblookup), 32'h0); advance();
      for (int i = 0; i < 3; i++) begin
         sample();
         check("cold_req", 32'(ptw_req), 32'h1);
         check("cold_addr", 32'(ptw_addr), 32'h1006);
         check("cold_walk_stall", 32'(enable_tlblookup), 32'h0);
         advance();
      end
      ptw_ack = 1'b1; ptw_data = 16'h8042; cycle(); ptw_ack = 1'b0;
      sample(); check("fill_stall", 32'(enable_tlblookup), 32'h0); advance();
      sample();
      check("cold_hit", 32'(hit), 32'h1);
      check("cold_paddr", 32'(paddr), 32'h42ABC);
      advance();

      // Hit path on the same page.
      set_req(1'b1, 1'b0, 16'h3123);
      sample();
      check("hitpath_hit", 32'(hit), 32'h1);
      check("hitpath_paddr", 32'(paddr), 32'h42123);
      check("hitpath_enable", 32'(enable_tlblookup), 32'h1);
      check("hitpath_noreq", 32'(ptw_req), 32'h0);
      advance();

      // Invalid PTE: one fault pulse, nothing filled, re-access walks again.
      set_req(1'b1, 1'b0, 16'h5000);
      cycle();
      finish_walk(0, 16'h0011);
      sample(); check("inv_fault", 32'(fault), 32'h1); advance();
      sample(); check("inv_rewalk_stall", 32'(enable_tlblookup), 32'h0); advance();
      sample();
      check("inv_rewalk_req", 32'(ptw_req), 32'h1);
      check("inv_rewalk_addr", 32'(ptw_addr), 32'h100A);
      advance();
      finish_walk(0, 16'h8055);
      cycle();

      // Write protection on a read-only page.
      fill(16'h2004, 16'h8007);
      set_req(1'b1, 1'b1, 16'h2004);
      sample();
      check("prot_fault", 32'(fault), 32'h1);
      check("prot_hit", 32'(hit), 32'h0);
      check("prot_enable", 32'(enable_tlblookup), 32'h1);
      advance();
      sample(); check("prot_no_walk", 32'(ptw_req), 32'h0); advance();
      set_req(1'b1, 1'b0, 16'h2004);
      sample();
      check("prot_load_hit", 32'(hit), 32'h1);
      check("prot_load_paddr", 32'(paddr), 32'h07004);
      advance();

      // Round-robin replacement: five fills into four slots evict vpn 0.
      do_reset();
      for (int v = 0; v < 5; v++) fill(16'((v << 12) | 32'h0ABC), 16'(32'h8010 + v));
      for (int v = 1; v < 5; v++) begin
         set_req(1'b1, 1'b0, 16'((v << 12) | 32'h0ABC));
         sample();
         check("repl_hit", 32'(hit), 32'h1);
         check("repl_paddr", 32'(paddr), ((32'h10 + v) << 12) | 32'hABC);
         advance();
      end
      set_req(1'b1, 1'b0, 16'h0ABC);
      sample(); check("repl_evicted", 32'(enable_tlblookup), 32'h0); advance();
      finish_walk(1, 16'h8030);
      cycle();

      // Flush during a walk discards its fill.
      set_req(1'b1, 1'b0, 16'h6000);
      cycle();
      flush = 1'b1; cycle(); flush = 1'b0;
      finish_walk(1, 16'h8066);
      sample();
      check("flush_walk_hit", 32'(hit), 32'h0);
      check("flush_walk_miss", 32'(enable_tlblookup), 32'h0);
      advance();
      finish_walk(0, 16'h8066);
      cycle();

      // Reset in the middle of a walk; previously filled pages then miss.
      set_req(1'b1, 1'b0, 16'h7000);
      cycle();
      cycle();
      do_reset();
      set_req(1'b1, 1'b0, 16'h6000);
      sample();
      check("post_rst_hit", 32'(hit), 32'h0);
      check("post_rst_miss", 32'(enable_tlblookup), 32'h0);
      advance();

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         if (m_phase == PH_WALK && $urandom_range(99) < 90) begin
            // hold the stalled request most of the time
         end else begin
            req_valid = ($urandom_range(99) < 70);
            req_store = ($urandom_range(99) < 35);
            req_vaddr = {4'($urandom_range(7)), 12'($urandom)};
         end
         flush = ($urandom_range(99) < 3);
         if ($urandom_range(19) == 0) ptbr = 16'($urandom);
         ptw_ack  = (m_phase == PH_WALK) ? ($urandom_range(99) < 35) : ($urandom_range(99) < 3);
         ptw_data = 16'($urandom);
         ptw_data[15] = ($urandom_range(99) < 80);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tlb_miss_controller.md
Name: tlb_miss_controller

Overview:
- Translation controller for the TLB-lookup pipeline stage.
- Holds a small fully-associative TLB and translates the 16-bit address coming out of the ALU.
- On a miss it stalls the stage by driving its enable low and walks a one-level page table through a memory request/ack handshake.
- It fills the TLB, then releases the stage. Invalid or write-protected pages are reported as a fault for the exception vector.

Parameters:
- ENTRIES, 4, number of TLB entries (power of two, 2..8)
- VPN_W, 4, virtual page number width; vaddr[15:16-VPN_W]
- PPN_W, 8, physical page number width; paddr = {ppn, vaddr[15-VPN_W:0]}

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  memory op present in stage (ldSt_enable != 0)
- req_store  in  1  op is a store
- req_vaddr  in  16  virtual address (alu_result)
- ptbr  in  16  page-table base byte address, sampled at walk start
- flush  in  1  invalidate all entries
- ptw_req  out  1  page-walk read request
- ptw_addr  out  16  PTE address = ptbr + {vpn,1'b0}
- ptw_ack  in  1  read data valid, one cycle
- ptw_data  in  16  PTE: [15]=valid, [14]=writable, [PPN_W-1:0]=ppn
- enable_tlblookup  out  1  stage enable; 0 = stall
- hit  out  1  translation valid this cycle
- paddr  out  16-VPN_W+PPN_W  physical address (20 bits at defaults)
- fault  out  1  page fault; drives ex_vector

Behaviour:
- Reset (reset=0, asynchronous):
  - all entry valid bits 0, replacement pointer 0, state IDLE, walk registers 0.
  - Outputs: ptw_req=0, ptw_addr=0, fault=0, hit=0, paddr=0, enable_tlblookup=1.
- Reset asserted mid-walk abandons the walk. A late ptw_ack after reset is ignored in IDLE.
- Lookup is combinational, zero latency. hit = req_valid & state==IDLE & a valid entry matches the VPN. paddr is driven from the matching entry, else 0.
- Permission: a store hitting an entry with writable=0 gives fault=1 in the same cycle and hit=0. No walk is started.
- enable_tlblookup = ~(req_valid & ~hit & ~fault) when in IDLE; 0 in WALK and FILL; 1 in FAULT.
- FSM states: IDLE, WALK, FILL, FAULT.
  - IDLE -> WALK: when req_valid & no match. Latch vpn, store flag, ptw_addr.
  - WALK: ptw_req=1 and held with a stable address until ptw_ack.
    - ack with PTE[15]=0, or a store with PTE[14]=0 -> FAULT.
    - otherwise -> FILL, latching the PTE.
  - FILL: write the entry at the replacement pointer (valid=1), then increment the pointer modulo ENTRIES. -> IDLE. The retried lookup hits on the next cycle.
  - FAULT: fault=1 for exactly one cycle, no fill -> IDLE.
- Replacement: round-robin, advanced only on a fill.
- The requested VPN is never already present at fill, so no duplicate entries are possible.
- Flush:
  - In IDLE: all valid bits clear on the next edge. A lookup in the same cycle still sees the old contents.
  - In WALK: the walk completes and the resulting fill is discarded. Return to IDLE, so a miss re-walks.
  - Flush and fill in the same cycle: flush wins.
- req_valid dropping during a walk: the walk still completes and fills. A FAULT in that case is suppressed (fault=0).

Optional Feature:
- TLB_STATS_EN defined adds two outputs:
  - miss_count[15:0]: increments on IDLE->WALK.
  - fault_count[7:0]: increments on every fault pulse, including the protection fault on a hit.
  - Both saturate at all-ones and clear on reset.
- Not defined: neither the ports nor the counters exist.

Decomposition:
- Shared package (tlb_pkg):
  - state encoding constants.
  - PTE bit positions: PTE_V=15, PTE_W=14.
  - default VPN_W / PPN_W.
- Sub-module tlb_array: entry storage, parallel match, fill write port, flush clear. The controller keeps the FSM, walk registers and replacement pointer.

Test Plan:
- Cold miss:
  - Stimulus: ptbr=0x1000, load vaddr=0x3ABC, ptw_ack after 3 cycles with ptw_data=0x8042.
  - Required: ptw_addr=0x1006; enable_tlblookup=0 until FILL; the next cycle has hit=1, paddr=0x42ABC.
- Hit path: repeat vaddr=0x3123 → hit=1, paddr=0x42123 in the same cycle, enable=1, no ptw_req.
- Invalid PTE: load vaddr=0x5000, ptw_data=0x0011 → one-cycle fault=1, no entry written, and a re-access walks again.
- Write protection:
  - fill vpn 2 with 0x8007; store to 0x2004 → fault=1 combinationally, hit=0, no walk.
  - a load to 0x2004 gives hit=1, paddr=0x07004.
- Replacement: fill vpns 0..4 in order → vpn 0 evicted (slot 0 reused), vpns 1-4 still hit.
- Flush and reset:
  - flush during WALK → after ack no hit for that vpn.
  - reset=0 mid-WALK → ptw_req=0 and enable=1 immediately; all lookups miss afterwards.
